scan_mux: RTL

- Parametrised, registered N:1 data multiplexer; generalises the 1-bit structural 4:1 mux to CHANNELS inputs of WIDTH bits.
- Adds an auto-scan mode that cycles through channels with a programmable dwell time.
- Used wherever several sensor/data lanes share one downstream consumer, e.g. a display or UART front-end.
- Manual mode gives classic addressed selection with one cycle of latency.

---
 rtl/scan_mux_pkg.sv | 27 ++
 rtl/scan_mux_scan_ptr.sv | 78 +++++++
 rtl/scan_mux.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_mux_pkg
// Shared definitions for the scan_mux block:
//   state_e - operating state of the mux (idle / manual select / auto-scan)
//   clog2   - constant-evaluable ceil(log2) used for parameter sizing checks
// -----------------------------------------------------------------------------
package scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_mux_scan_ptr.sv
// -----------------------------------------------------------------------------
// scan_ptr
// Scan pointer with programmable dwell. Holds each channel index for DWELL
// enabled cycles, then steps to the next channel, wrapping CHANNELS-1 -> 0.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   advance_en  count/advance this cycle (scan state active)
//   restart     treat the pointer and dwell counter as zero this cycle
//   ptr         channel index to sample this cycle
//   wrap        high on the first cycle that samples channel 0 after a wrap
// -----------------------------------------------------------------------------
module scan_ptr
  import scan_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance_en,
  input  logic             restart,
  output logic [SEL_W-1:0] ptr,
  output logic             wrap
);

  localparam int DCNT_W = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [SEL_W-1:0]  PTR_LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

  logic [SEL_W-1:0]  ptr_q, ptr_d, ptr_eff;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_eff;
  logic              wrap_q, wrap_d;

  // A restart makes this cycle behave as channel 0 / dwell 0, so the first
  // sample after entering scan is channel 0 and it still gets a full dwell.
  always_comb begin
    ptr_eff  = restart ? '0 : ptr_q;
    dcnt_eff = restart ? '0 : dcnt_q;
    ptr_d    = ptr_q;
    dcnt_d   = dcnt_q;
    wrap_d   = wrap_q;
    if (advance_en) begin
      wrap_d = 1'b0;
      ptr_d  = ptr_eff;
      if (dcnt_eff == DCNT_LAST) begin
        dcnt_d = '0;
        if (ptr_eff == PTR_LAST) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_eff + SEL_W'(1);
        end
      end else begin
        dcnt_d = dcnt_eff + DCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      dcnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      dcnt_q <= dcnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr = ptr_eff;
  // wrap_q is held through idle so a resumed scan still flags its first ch0.
  assign wrap = wrap_q && !restart;

endmodule

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
// Registered CHANNELS:1 multiplexer of WIDTH-bit lanes with manual addressed
// selection or auto-scan (each channel held for DWELL cycles).
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   en         enable; low freezes all state (outputs invalid)
//   mode       0 = manual (address by sel), 1 = auto-scan
//   sel        manual channel address
//   in_flat    channel k at bits [k*WIDTH +: WIDTH]
//   out        registered selected data
//   out_sel    channel index that produced out
//   out_valid  out/out_sel updated with legal data this cycle
//   wrap       pulse on the first sample of channel 0 after a scan wrap
// -----------------------------------------------------------------------------
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_flat,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  output logic                      wrap
);

  if (SEL_W != clog2(CHANNELS)) begin : g_bad_sel_w
    $error("scan_mux: SEL_W must equal clog2(CHANNELS)");
  end
  if (CHANNELS < 2) begin : g_bad_channels
    $error("scan_mux: CHANNELS must be at least 2");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("scan_mux: DWELL must be at least 1");
  end

  state_e state_q, state_d;
  logic   scan_hist_q, scan_hist_d;
  logic   restart;

  logic [WIDTH-1:0] ch [CHANNELS];
  logic [SEL_W-1:0] ptr;
  logic             ptr_wrap;
  logic             sel_ok;
  logic [WIDTH-1:0] sel_data, ptr_data;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch[k] = in_flat[k*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = mode ? ST_SCAN : ST_MANUAL;
    end
  end

  // scan_hist remembers the last active state across idle, so an en drop
  // during scan resumes mid-dwell while a manual episode forces a restart.
  always_comb begin
    scan_hist_d = scan_hist_q;
    if (state_d == ST_SCAN) begin
      scan_hist_d = 1'b1;
    end else if (state_d == ST_MANUAL) begin
      scan_hist_d = 1'b0;
    end
  end

  assign restart = (state_d == ST_SCAN) && (state_q != ST_SCAN) && !scan_hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      scan_hist_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_hist_q <= scan_hist_d;
    end
  end

  scan_ptr #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .DWELL    (DWELL)
  ) u_scan_ptr (
    .clk        (clk),
    .reset      (reset),
    .advance_en (state_d == ST_SCAN),
    .restart    (restart),
    .ptr        (ptr),
    .wrap       (ptr_wrap)
  );

  // Loop-based selection: an out-of-range sel matches no channel, which is
  // how illegal addresses are detected for non-power-of-2 CHANNELS.
  always_comb begin
    sel_ok   = 1'b0;
    sel_data = '0;
    ptr_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_ok   = 1'b1;
        sel_data = ch[k];
      end
      if (ptr == SEL_W'(k)) begin
        ptr_data = ch[k];
      end
    end
  end

  always_comb begin
    out_d     = out_q;
    out_sel_d = out_sel_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    case (state_d)
      ST_MANUAL: begin
        if (sel_ok) begin
          out_d     = sel_data;
          out_sel_d = sel;
          valid_d   = 1'b1;
        end
      end
      ST_SCAN: begin
        out_d     = ptr_data;
        out_sel_d = ptr;
        valid_d   = 1'b1;
        wrap_d    = ptr_wrap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_sel_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_sel_q <= out_sel_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;

endmodule
